// File: rtl/hdmi_pkg.sv
// Shared types, symbol tables and BCH helper
// for the HDMI data-island scheduler.
package hdmi_pkg;

  localparam int ISLAND_PRE_LEN = 8;
  localparam int GUARD_LEN      = 2;
  localparam int PKT_LEN        = 32;

  localparam logic [7:0] BCH_POLY  = 8'b10000011;
  localparam logic [9:0] PRE_SYM   = 10'b0010101011;
  localparam logic [9:0] GUARD_SYM = 10'b0100110011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_LGRD,
    S_DATA,
    S_TGRD
  } state_t;

  typedef struct packed {
    logic [223:0] body;
    logic [23:0]  hdr;
  } pkt_t;

  function automatic logic [9:0] terc4(input logic [3:0] d);
    logic [9:0] s;
    case (d)
      4'h0: s = 10'b1010011100;
      4'h1: s = 10'b1001100011;
      4'h2: s = 10'b1011100100;
      4'h3: s = 10'b1011100010;
      4'h4: s = 10'b0101110001;
      4'h5: s = 10'b0100011110;
      4'h6: s = 10'b0110001110;
      4'h7: s = 10'b0100111100;
      4'h8: s = 10'b1011001100;
      4'h9: s = 10'b0100111001;
      4'ha: s = 10'b0110011100;
      4'hb: s = 10'b1011000110;
      4'hc: s = 10'b1010001110;
      4'hd: s = 10'b1001110001;
      4'he: s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  // c = {vsync, hsync}
  function automatic logic [9:0] ctl_token(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00: s = 10'b1101010100;
      2'b01: s = 10'b0010101011;
      2'b10: s = 10'b0101010100;
      default: s = 10'b1010101011;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] bch_step(
    input logic [7:0] e,
    input logic       d
  );
    return (e >> 1) ^ ((e[0] ^ d) ? BCH_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/hdmi_island_scheduler_if.sv
// Packet handshake bundle into the
// data-island scheduler FIFO.
interface hdmi_island_scheduler_if;
  logic         pkt_valid;
  logic         pkt_ready;
  logic [23:0]  pkt_hdr;
  logic [223:0] pkt_body;

  modport master (
    output pkt_valid, pkt_hdr, pkt_body,
    input  pkt_ready
  );

  modport slave (
    input  pkt_valid, pkt_hdr, pkt_body,
    output pkt_ready
  );
endinterface

// File: rtl/hdmi_bch_lane.sv
// Serialises header or subpacket data LSB
// first, then the BCH parity byte.
module hdmi_bch_lane
  import hdmi_pkg::*;
#(
  parameter int BITS_PER_CLK = 1,
  localparam int DATA_BITS =
    (BITS_PER_CLK == 1) ? 24 : 56
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    step,
  input  logic                    par,
  input  logic [DATA_BITS-1:0]    data_in,
  output logic [BITS_PER_CLK-1:0] bits_out
);

  logic [DATA_BITS-1:0] sh;
  logic [7:0]           ecc;
  logic [7:0]           ecc_nxt;

  always_comb begin
    ecc_nxt = ecc;
    for (int i = 0; i < BITS_PER_CLK; i++)
      ecc_nxt = bch_step(ecc_nxt, sh[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh  <= '0;
      ecc <= '0;
    end else if (load) begin
      sh  <= data_in;
      ecc <= '0;
    end else if (step) begin
      if (par) begin
        ecc <= ecc >> BITS_PER_CLK;
      end else begin
        ecc <= ecc_nxt;
        sh  <= sh >> BITS_PER_CLK;
      end
    end
  end

  assign bits_out = par ? ecc[BITS_PER_CLK-1:0]
                        : sh[BITS_PER_CLK-1:0];

endmodule

// File: rtl/hdmi_island_scheduler.sv
// Data-island scheduler: packet FIFO, blank
// counter, island FSM and TERC4 symbol output.
module hdmi_island_scheduler
  import hdmi_pkg::*;
#(
  parameter int MAX_PACKETS  = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int ISLAND_START = 8,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   de,
  input  logic                   hsync,
  input  logic                   vsync,
  hdmi_island_scheduler_if.slave pkt_if,
  output logic [29:0]            sym,
  output logic                   sym_active,
  output logic [LW-1:0]          fifo_level,
  output logic                   abort
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(MAX_PACKETS + 1);
  localparam int BW = $clog2(ISLAND_START + 2);

  state_t         state, state_d;
  logic           de_q;
  logic [BW-1:0]  bc;
  logic [4:0]     cnt;
  logic [PW-1:0]  pkt_idx, n_pk, n_d;
  pkt_t           mem [FIFO_DEPTH];
  pkt_t           head;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           push, pop, start, kill;
  logic           last_pkt, pkt_start;
  logic           hdr_bit;
  logic [3:0][1:0] sp_bits;
  logic [1:0]     c;
  logic [3:0]     ch0_n;
  logic [29:0]    sym_d;
  logic           active_d;

  assign c = {vsync, hsync};
  assign pkt_if.pkt_ready =
    (fifo_level != LW'(FIFO_DEPTH));
  assign push = pkt_if.pkt_valid & pkt_if.pkt_ready;
  assign head = mem[rd_ptr];

  assign start = ~de & (bc == BW'(ISLAND_START))
               & (fifo_level != '0);
  assign kill = de & ~de_q & (state != S_IDLE);
  assign last_pkt = (pkt_idx + PW'(1)) == n_pk;
  assign pkt_start = ~kill & (
    (state == S_LGRD && cnt == 5'(GUARD_LEN - 1)) ||
    (state == S_DATA && cnt == 5'(PKT_LEN - 1) &&
     !last_pkt));
  assign pop = pkt_start & (fifo_level != '0);

  always_comb begin
    if (fifo_level > LW'(MAX_PACKETS))
      n_d = PW'(MAX_PACKETS);
    else
      n_d = PW'(fifo_level);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:
        if (start) state_d = S_PRE;
      S_PRE:
        if (cnt == 5'(ISLAND_PRE_LEN - 1))
          state_d = S_LGRD;
      S_LGRD:
        if (cnt == 5'(GUARD_LEN - 1))
          state_d = S_DATA;
      S_DATA:
        if (cnt == 5'(PKT_LEN - 1) && last_pkt)
          state_d = S_TGRD;
      S_TGRD:
        if (cnt == 5'(GUARD_LEN - 1))
          state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
  end

  always_comb begin
    sym_d    = '0;
    active_d = 1'b0;
    ch0_n    = {(cnt != '0) || (pkt_idx != '0),
                hdr_bit, c};
    unique case (state)
      S_PRE: begin
        active_d = 1'b1;
        sym_d = {PRE_SYM, PRE_SYM, ctl_token(c)};
      end
      S_LGRD, S_TGRD: begin
        active_d = 1'b1;
        sym_d = {GUARD_SYM, GUARD_SYM,
                 terc4({2'b11, c})};
      end
      S_DATA: begin
        active_d = 1'b1;
        sym_d = {
          terc4({sp_bits[3][1], sp_bits[2][1],
                 sp_bits[1][1], sp_bits[0][1]}),
          terc4({sp_bits[3][0], sp_bits[2][0],
                 sp_bits[1][0], sp_bits[0][0]}),
          terc4(ch0_n)};
      end
      default: ;
    endcase
    if (kill) begin
      sym_d    = '0;
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sym        <= '0;
      sym_active <= 1'b0;
      abort      <= 1'b0;
    end else begin
      sym        <= sym_d;
      sym_active <= active_d;
      if (kill) abort <= 1'b1;
    end
  end

  // bc saturates above ISLAND_START so each blank starts at most once
  always_ff @(posedge clk) begin
    if (rst) begin
      de_q <= 1'b0;
      bc   <= '0;
    end else begin
      de_q <= de;
      if (de)
        bc <= '0;
      else if (bc != '1)
        bc <= bc + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      pkt_idx <= '0;
      n_pk    <= '0;
    end else begin
      if (state_d != state || pkt_start ||
          state_d == S_IDLE)
        cnt <= '0;
      else
        cnt <= cnt + 5'd1;
      if (state == S_IDLE) begin
        pkt_idx <= '0;
        if (start) n_pk <= n_d;
      end else if (state == S_DATA && pkt_start) begin
        pkt_idx <= pkt_idx + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {pkt_if.pkt_body, pkt_if.pkt_hdr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10: fifo_level <= fifo_level + LW'(1);
        2'b01: fifo_level <= fifo_level - LW'(1);
        default: ;
      endcase
    end
  end

  hdmi_bch_lane #(.BITS_PER_CLK(1)) u_hdr (
    .clk      (clk),
    .rst      (rst),
    .load     (pop),
    .step     (state == S_DATA),
    .par      (cnt >= 5'd24),
    .data_in  (head.hdr),
    .bits_out (hdr_bit)
  );

  for (genvar i = 0; i < 4; i++) begin : g_sp
    hdmi_bch_lane #(.BITS_PER_CLK(2)) u_sp (
      .clk      (clk),
      .rst      (rst),
      .load     (pop),
      .step     (state == S_DATA),
      .par      (cnt >= 5'd28),
      .data_in  (head.body[56*i +: 56]),
      .bits_out (sp_bits[i])
    );
  end

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Directed bench for the data-island scheduler
// with hand-derived symbol streams.
module tb_hdmi_island_scheduler;

  logic        clk = 1'b0;
  logic        rst, de, hsync, vsync;
  logic [29:0] sym;
  logic        sym_active;
  logic [3:0]  fifo_level;
  logic        abort;

  always #5 clk = ~clk;

  hdmi_island_scheduler_if pkt_if ();

  hdmi_island_scheduler #(
    .MAX_PACKETS  (3),
    .FIFO_DEPTH   (8),
    .ISLAND_START (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .de         (de),
    .hsync      (hsync),
    .vsync      (vsync),
    .pkt_if     (pkt_if),
    .sym        (sym),
    .sym_active (sym_active),
    .fifo_level (fifo_level),
    .abort      (abort)
  );

  localparam logic [9:0] PRE = 10'b0010101011;
  localparam logic [9:0] GRD = 10'b0100110011;

  logic [9:0] t4 [16] = '{
    10'b1010011100, 10'b1001100011,
    10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110,
    10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001,
    10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001,
    10'b0101100011, 10'b1011000011};
  logic [9:0] ctl [4] = '{
    10'b1101010100, 10'b0010101011,
    10'b0101010100, 10'b1010101011};

  logic [29:0] cap_sym [160];
  logic        cap_act [160];
  logic [3:0]  cap_lvl [160];
  logic        cap_rdy [160];
  logic        cap_abt [160];
  int          n_act, first_act;
  int          checks = 0;
  int          errors = 0;

  logic [23:0]  h2;
  logic [223:0] b2;
  logic [31:0]  hs;
  logic [63:0]  sp [4];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [23:0] h,
                      input logic [223:0] b);
    pkt_if.pkt_hdr   = h;
    pkt_if.pkt_body  = b;
    pkt_if.pkt_valid = 1'b1;
    tick();
    pkt_if.pkt_valid = 1'b0;
  endtask

  task automatic blank(input int n, input int push_at,
                       input int de_at, input int rst_at);
    de = 1'b0;
    n_act = 0;
    first_act = -1;
    for (int i = 0; i < n; i++) begin
      pkt_if.pkt_valid = (i == push_at);
      if (i == de_at) de = 1'b1;
      rst = (i == rst_at);
      tick();
      cap_sym[i] = sym;
      cap_act[i] = sym_active;
      cap_lvl[i] = fifo_level;
      cap_rdy[i] = pkt_if.pkt_ready;
      cap_abt[i] = abort;
      if (sym_active) begin
        n_act++;
        if (first_act < 0) first_act = i;
      end
    end
    pkt_if.pkt_valid = 1'b0;
    rst = 1'b0;
    de = 1'b1;
    tick();
    tick();
  endtask

  function automatic logic [29:0] dsym(
    input logic [3:0] c0, input logic [3:0] c1,
    input logic [3:0] c2);
    return {t4[c2], t4[c1], t4[c0]};
  endfunction

  function automatic logic [7:0] ecc_of(
    input logic [55:0] d, input int nb);
    logic [7:0] e;
    logic fb;
    e = 8'h00;
    for (int i = 0; i < nb; i++) begin
      fb = e[0] ^ d[i];
      e = e >> 1;
      if (fb) e = e ^ 8'h83;
    end
    return e;
  endfunction

  initial begin
    rst = 1'b1; de = 1'b1;
    hsync = 1'b0; vsync = 1'b0;
    pkt_if.pkt_valid = 1'b0;
    pkt_if.pkt_hdr = '0;
    pkt_if.pkt_body = '0;
    repeat (3) tick();
    check("rst sym", sym, 0);
    check("rst act", sym_active, 0);
    check("rst abort", abort, 0);
    check("rst level", fifo_level, 0);
    check("rst ready", pkt_if.pkt_ready, 1);
    rst = 1'b0;
    tick();

    // 1: single all-zero packet
    push(24'h0, 224'h0);
    check("t1 level", fifo_level, 1);
    blank(60, -1, -1, -1);
    check("t1 nact", n_act, 44);
    check("t1 first", first_act, 9);
    check("t1 pre0", cap_sym[9], {PRE, PRE, ctl[0]});
    check("t1 pre7", cap_sym[16], {PRE, PRE, ctl[0]});
    check("t1 lgrd", cap_sym[17], {GRD, GRD, t4[12]});
    check("t1 lgrd1", cap_sym[18], {GRD, GRD, t4[12]});
    check("t1 d0", cap_sym[19], dsym(4'h0, 4'h0, 4'h0));
    check("t1 d1", cap_sym[20], dsym(4'h8, 4'h0, 4'h0));
    check("t1 d31", cap_sym[50], dsym(4'h8, 4'h0, 4'h0));
    check("t1 tgrd", cap_sym[52], {GRD, GRD, t4[12]});
    check("t1 end", cap_act[53], 0);
    check("t1 lvl", fifo_level, 0);

    // 2: header/body against serial BCH model
    h2 = 24'h0d0282;
    for (int b = 0; b < 28; b++)
      b2[8*b +: 8] = 8'(b * 29 + 5);
    hs = {ecc_of({32'h0, h2}, 24), h2};
    for (int i = 0; i < 4; i++)
      sp[i] = {ecc_of(b2[56*i +: 56], 56), b2[56*i +: 56]};
    push(h2, b2);
    blank(60, -1, -1, -1);
    for (int k = 0; k < 32; k++)
      check($sformatf("t2 k%0d", k), cap_sym[19 + k],
        dsym({k != 0, hs[k], 2'b00},
             {sp[3][2*k], sp[2][2*k], sp[1][2*k], sp[0][2*k]},
             {sp[3][2*k+1], sp[2][2*k+1],
              sp[1][2*k+1], sp[0][2*k+1]}));

    // 3: five queued, three per line
    for (int p = 0; p < 5; p++) push(24'(p), 224'h0);
    check("t3 lvl5", fifo_level, 5);
    blank(130, -1, -1, -1);
    check("t3 nact", n_act, 108);
    check("t3 p1", cap_sym[51], dsym(4'hc, 4'h0, 4'h0));
    check("t3 p2", cap_sym[83], dsym(4'h8, 4'h0, 4'h0));
    check("t3 lvl2", fifo_level, 2);
    hsync = 1'b1;
    blank(130, -1, -1, -1);
    hsync = 1'b0;
    check("t3b nact", n_act, 76);
    check("t3b pre", cap_sym[9], {PRE, PRE, ctl[1]});
    check("t3b grd", cap_sym[17], {GRD, GRD, t4[13]});
    check("t3b p0", cap_sym[19], dsym(4'h5, 4'h0, 4'h0));
    check("t3b lvl0", fifo_level, 0);

    // 4: full FIFO, then push alongside a pop
    for (int p = 0; p < 8; p++) push(24'(p), 224'h0);
    check("t4 full lvl", fifo_level, 8);
    check("t4 not rdy", pkt_if.pkt_ready, 0);
    push(24'hff, 224'h0);
    check("t4 ign", fifo_level, 8);
    pkt_if.pkt_hdr = 24'h9;
    blank(130, 50, -1, -1);
    check("t4 l17", cap_lvl[17], 8);
    check("t4 l18", cap_lvl[18], 7);
    check("t4 rdy49", cap_rdy[49], 1);
    check("t4 l50", cap_lvl[50], 7);
    check("t4 l82", cap_lvl[82], 6);
    check("t4 lvl6", fifo_level, 6);
    blank(130, -1, -1, -1);
    check("t4 n2", n_act, 108);
    check("t4 lvl3", fifo_level, 3);
    blank(130, -1, -1, -1);
    check("t4 n3", n_act, 108);
    check("t4 lvl0", fifo_level, 0);

    // 5: DE rises at DATA clock 10 of packet 0
    for (int p = 0; p < 3; p++) push(24'(p), 224'h0);
    blank(60, -1, 29, -1);
    check("t5 act28", cap_act[28], 1);
    check("t5 act29", cap_act[29], 0);
    check("t5 abt28", cap_abt[28], 0);
    check("t5 abt29", cap_abt[29], 1);
    check("t5 lvl", fifo_level, 2);
    check("t5 abort", abort, 1);

    // 6: reset at PRE clock 3 with two queued
    blank(40, -1, -1, 12);
    check("t6 abt11", cap_abt[11], 1);
    check("t6 act11", cap_act[11], 1);
    check("t6 act12", cap_act[12], 0);
    check("t6 lvl12", cap_lvl[12], 0);
    check("t6 rdy12", cap_rdy[12], 1);
    check("t6 abt12", cap_abt[12], 0);
    check("t6 nact", n_act, 3);
    check("t6 lvl", fifo_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
